axi4_traffic_gen: RTL and testbench

//  AXI4 master feeding the slave port of axi4_bridge (upstream stage). On start it writes
//  NUM_BURSTS INCR bursts of an address-derived pattern, reads them back and compares.

---
 rtl/axi4_pkg.sv | 26 ++
 rtl/axi4_rd_checker.sv | 59 +++++
 rtl/axi4_traffic_gen.sv | 203 ++++++++++++++++++++
 tb/tb_axi4_traffic_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 memory self-test traffic generator.
//   AXI_RESP_OKAY / AXI_BURST_INCR : AXI encodings used by the generator
//   tg_state_e                     : generator FSM state encoding
//   pattern_word()                 : 32-bit test pattern for one byte address
package axi4_pkg;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StDone
  } tg_state_e;

  // Data beats carry the beat's byte address XORed with a seed, replicated to the bus width.
  function automatic logic [31:0] pattern_word(input logic [31:0] addr,
                                               input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/axi4_rd_checker.sv
// Read-back checker for the traffic generator: regenerates the expected beat, compares the
// returned beat and its flags, and keeps a saturating error count.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clr_i           : synchronous clear of the error count (new test start)
//   b_fire_i/bresp_i: write response handshake and response code
//   r_fire_i        : read beat handshake; rdata_i/rresp_i/rlast_i are its payload
//   beat_addr_i     : byte address of the current read beat
//   last_beat_i     : current beat is the last of its burst
//   err_cnt_o       : saturating error count
module axi4_rd_checker
  import axi4_pkg::*;
#(
  parameter int unsigned     ADDR_WIDTH = 32,
  parameter int unsigned     DATA_WIDTH = 64,
  parameter logic [31:0]     SEED       = 32'hA5A5_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  b_fire_i,
  input  logic [1:0]            bresp_i,
  input  logic                  r_fire_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic [ADDR_WIDTH-1:0] beat_addr_i,
  input  logic                  last_beat_i,
  output logic [15:0]           err_cnt_o
);

  logic [DATA_WIDTH-1:0] exp_data;
  logic [2:0]            inc;
  logic [16:0]           sum;
  logic [15:0]           err_d, err_q;

  assign exp_data = {(DATA_WIDTH / 32){pattern_word(32'(beat_addr_i), SEED)}};

  // Each error source contributes at most one per beat; B and R never fire together.
  always_comb begin
    inc = '0;
    if (b_fire_i && (bresp_i != AXI_RESP_OKAY)) inc = inc + 3'd1;
    if (r_fire_i) begin
      if (rdata_i != exp_data)         inc = inc + 3'd1;
      if (rresp_i != AXI_RESP_OKAY)    inc = inc + 3'd1;
      if (rlast_i != last_beat_i)      inc = inc + 3'd1;
    end
  end

  assign sum   = {1'b0, err_q} + 17'(inc);
  assign err_d = sum[16] ? 16'hFFFF : sum[15:0];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) err_q <= '0;
    else                err_q <= err_d;
  end

  assign err_cnt_o = err_q;

endmodule

// File: rtl/axi4_traffic_gen.sv
// AXI4 memory self-test master: writes NUM_BURSTS INCR bursts of an address-derived pattern,
// reads them back and checks them.
//   clk_25MHz, rst   : clock, synchronous active-high reset
//   calib_done       : memory path ready; start is honoured only while it is high
//   start            : level, sampled in idle/done
//   m_axi_aw*/w*/b*  : write address, data and response channels
//   m_axi_ar*/r*     : read address and data channels
//   busy/done/pass   : test status; err_cnt is the saturating error count
module axi4_traffic_gen
  import axi4_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           BURST_LEN  = 16,
  parameter int unsigned           NUM_BURSTS = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           SEED       = 32'hA5A5_0000
) (
  input  logic                      clk_25MHz,
  input  logic                      rst,
  input  logic                      calib_done,
  input  logic                      start,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               err_cnt
);

  localparam int unsigned           BYTES       = DATA_WIDTH / 8;
  localparam int unsigned           KW          = $clog2(NUM_BURSTS) + 1;
  localparam logic [7:0]            LEN_M1      = 8'(BURST_LEN - 1);
  localparam logic [KW-1:0]         LAST_K      = KW'(NUM_BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BYTES);

  tg_state_e             state_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  busy_q, done_q;
  logic [ADDR_WIDTH-1:0] burst_addr_q;
  logic [7:0]            beat_q;
  logic [KW-1:0]         k_q;

  logic                  launch, last_beat, last_burst, b_fire, r_fire;
  logic [ADDR_WIDTH-1:0] beat_addr;

  assign launch     = start && calib_done && (state_q == StIdle || state_q == StDone);
  assign last_beat  = (beat_q == LEN_M1);
  assign last_burst = (k_q == LAST_K);
  assign b_fire     = m_axi_bvalid && bready_q;
  assign r_fire     = m_axi_rvalid && rready_q;
  assign beat_addr  = burst_addr_q + (ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BYTES));

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q      <= StIdle;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      burst_addr_q <= '0;
      beat_q       <= '0;
      k_q          <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (launch) begin
            state_q      <= StAw;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            k_q          <= '0;
            beat_q       <= '0;
            burst_addr_q <= BASE_ADDR;
          end
        end
        StAw: begin
          // Valid rises the cycle after entry; payload is the held burst address.
          if (!awvalid_q) begin
            awvalid_q <= 1'b1;
          end else if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= StW;
          end
        end
        StW: begin
          if (wvalid_q && m_axi_wready) begin
            if (last_beat) begin
              wvalid_q <= 1'b0;
              beat_q   <= '0;
              bready_q <= 1'b1;
              state_q  <= StB;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        StB: begin
          if (b_fire) begin
            bready_q <= 1'b0;
            if (last_burst) begin
              k_q          <= '0;
              burst_addr_q <= BASE_ADDR;
              state_q      <= StAr;
            end else begin
              k_q          <= k_q + KW'(1);
              burst_addr_q <= burst_addr_q + BURST_BYTES;
              state_q      <= StAw;
            end
          end
        end
        StAr: begin
          if (!arvalid_q) begin
            arvalid_q <= 1'b1;
          end else if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StR;
          end
        end
        StR: begin
          // Burst ends on the beat count, not on rlast; a bad rlast is only counted.
          if (r_fire) begin
            if (last_beat) begin
              rready_q <= 1'b0;
              beat_q   <= '0;
              if (last_burst) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                k_q          <= k_q + KW'(1);
                burst_addr_q <= burst_addr_q + BURST_BYTES;
                state_q      <= StAr;
              end
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axi4_rd_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SEED       (SEED)
  ) u_rd_checker (
    .clk_i       (clk_25MHz),
    .rst_i       (rst),
    .clr_i       (launch),
    .b_fire_i    (b_fire),
    .bresp_i     (m_axi_bresp),
    .r_fire_i    (r_fire),
    .rdata_i     (m_axi_rdata),
    .rresp_i     (m_axi_rresp),
    .rlast_i     (m_axi_rlast),
    .beat_addr_i (beat_addr),
    .last_beat_i (last_beat),
    .err_cnt_o   (err_cnt)
  );

  assign m_axi_awaddr  = burst_addr_q;
  assign m_axi_awlen   = LEN_M1;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = {(DATA_WIDTH / 32){pattern_word(32'(beat_addr), SEED)}};
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wvalid_q && last_beat;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = burst_addr_q;
  assign m_axi_arlen   = LEN_M1;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = done_q && (err_cnt == 16'd0);

endmodule

// File: tb/tb_axi4_traffic_gen.sv
// Directed bench for axi4_traffic_gen with a small behavioural AXI slave (memory-backed,
// optional random stalls and fault injection).
module tb_axi4_traffic_gen;

  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, calib_done, start;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_wdata, m_axi_rdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        busy, done, pass;
  logic [15:0] err_cnt;

  always #20 clk = ~clk;

  axi4_traffic_gen #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .BURST_LEN  (4),
    .NUM_BURSTS (2),
    .BASE_ADDR  (32'h0),
    .SEED       (SEED)
  ) dut (
    .clk_25MHz     (clk),
    .rst           (rst),
    .calib_done    (calib_done),
    .start         (start),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave state and fault-injection controls.
  bit          stall_en, bresp_err0, drop_rlast;
  int          flip_beat;
  int          b_pending, b_count, w_beat, r_beat, w_total, r_total, aw_n, ar_n;
  int          stab_viol, wdata_bad, wlast_bad, len_bad;
  logic [31:0] aw_log [0:7];
  logic [31:0] ar_log [0:7];
  logic [31:0] wq [$];
  logic [31:0] rq [$];
  logic [63:0] mem [0:15];
  bit          p_awv, p_awf, p_wv, p_wf, p_arv, p_arf;
  logic [31:0] p_awaddr, p_araddr;
  logic [63:0] p_wdata;

  task automatic slave_clear();
    b_pending = 0; b_count = 0; w_beat = 0; r_beat = 0; w_total = 0; r_total = 0;
    aw_n = 0; ar_n = 0; stab_viol = 0; wdata_bad = 0; wlast_bad = 0; len_bad = 0;
    wq.delete(); rq.delete();
    for (int i = 0; i < 16; i++) mem[i] = 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < 8; i++) begin aw_log[i] = '1; ar_log[i] = '1; end
  endtask

  // Slave works on the falling edge: readies chosen here are what the next rising edge sees,
  // so handshakes are recorded here, one half-cycle before the DUT observes them.
  initial begin
    logic [31:0] a;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0;
        m_axi_rvalid = 0; m_axi_rlast = 0;
        p_awv = 0; p_awf = 0; p_wv = 0; p_wf = 0; p_arv = 0; p_arf = 0;
      end else begin
        if (p_awv && !p_awf && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) stab_viol++;
        if (p_wv && !p_wf && (!m_axi_wvalid || m_axi_wdata !== p_wdata)) stab_viol++;
        if (p_arv && !p_arf && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) stab_viol++;
        // B
        if (b_pending > 0) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = (bresp_err0 && b_count == 0) ? 2'b10 : 2'b00;
          if (m_axi_bready) begin b_pending--; b_count++; end
        end else begin
          m_axi_bvalid = 0; m_axi_bresp = 0;
        end
        // W
        m_axi_wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        p_wf = m_axi_wvalid && m_axi_wready;
        if (p_wf) begin
          if (wq.size() == 0) begin
            wdata_bad++;
          end else begin
            a = wq[0] + 32'(w_beat * 8);
            if (m_axi_wdata !== {2{a ^ SEED}}) wdata_bad++;
            if (m_axi_wlast !== (w_beat == 3)) wlast_bad++;
            mem[a[6:3]] = m_axi_wdata;
            w_beat++; w_total++;
            if (w_beat == 4) begin w_beat = 0; void'(wq.pop_front()); b_pending++; end
          end
        end
        // AW
        m_axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        p_awf = m_axi_awvalid && m_axi_awready;
        if (p_awf) begin
          if (aw_n < 8) aw_log[aw_n] = m_axi_awaddr;
          aw_n++;
          if (m_axi_awlen !== 8'd3) len_bad++;
          wq.push_back(m_axi_awaddr);
        end
        // R
        if (rq.size() > 0) begin
          m_axi_rvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
          a = rq[0] + 32'(r_beat * 8);
          m_axi_rdata = mem[a[6:3]];
          if (r_total == flip_beat) m_axi_rdata[0] = ~m_axi_rdata[0];
          m_axi_rresp = 2'b00;
          m_axi_rlast = (r_beat == 3) && !(drop_rlast && r_total == 7);
          if (m_axi_rvalid && m_axi_rready) begin
            r_beat++; r_total++;
            if (r_beat == 4) begin r_beat = 0; void'(rq.pop_front()); end
          end
        end else begin
          m_axi_rvalid = 0; m_axi_rlast = 0;
        end
        // AR
        m_axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        p_arf = m_axi_arvalid && m_axi_arready;
        if (p_arf) begin
          if (ar_n < 8) ar_log[ar_n] = m_axi_araddr;
          ar_n++;
          if (m_axi_arlen !== 8'd3) len_bad++;
          rq.push_back(m_axi_araddr);
        end
        p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
        p_wv  = m_axi_wvalid;  p_wdata  = m_axi_wdata;
        p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
      end
    end
  end

  // Main flow drives and samples 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (done) break;
      tick();
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic run_test(input string tag);
    slave_clear();
    start = 1;
    tick();
    start = 0;
    wait_done(tag);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_awvalid"}, m_axi_awvalid, 1'b0);
    check({tag, "_wvalid"},  m_axi_wvalid,  1'b0);
    check({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    check({tag, "_bready"},  m_axi_bready,  1'b0);
    check({tag, "_rready"},  m_axi_rready,  1'b0);
    check({tag, "_busy"},    busy,          1'b0);
    check({tag, "_done"},    done,          1'b0);
    check({tag, "_pass"},    pass,          1'b0);
    check({tag, "_err"},     err_cnt,       16'd0);
  endtask

  initial begin
    int seen;
    rst = 1; calib_done = 1; start = 0;
    stall_en = 0; bresp_err0 = 0; drop_rlast = 0; flip_beat = -1;
    slave_clear();
    repeat (3) tick();
    rst = 0;
    check_idle("reset");

    // 1: ideal slave
    run_test("ideal");
    check("ideal_pass", pass, 1'b1);
    check("ideal_err", err_cnt, 16'd0);
    check("ideal_busy", busy, 1'b0);
    check("ideal_wbeats", w_total, 8);
    check("ideal_rbeats", r_total, 8);
    check("ideal_aw0", aw_log[0], 32'h0);
    check("ideal_aw1", aw_log[1], 32'h20);
    check("ideal_ar1", ar_log[1], 32'h20);
    check("ideal_wdata_bad", wdata_bad, 0);
    check("ideal_wlast_bad", wlast_bad, 0);
    check("ideal_len_bad", len_bad, 0);
    check("ideal_wstrb", m_axi_wstrb, 8'hFF);

    // 2: corrupted read beat 5
    flip_beat = 5;
    run_test("flip");
    check("flip_err", err_cnt, 16'd1);
    check("flip_pass", pass, 1'b0);
    flip_beat = -1;

    // 3: random stalls; restart must also clear the previous error
    stall_en = 1;
    run_test("stall");
    check("stall_pass", pass, 1'b1);
    check("stall_err", err_cnt, 16'd0);
    check("stall_stable", stab_viol, 0);
    check("stall_wdata_bad", wdata_bad, 0);
    check("stall_rbeats", r_total, 8);
    stall_en = 0;

    // 4: bad bresp on burst 0 plus missing rlast on final beat
    bresp_err0 = 1; drop_rlast = 1;
    run_test("resp");
    check("resp_err", err_cnt, 16'd2);
    check("resp_pass", pass, 1'b0);
    bresp_err0 = 0; drop_rlast = 0;

    // 5: start held while calibration is not done
    rst = 1; tick(); rst = 0;
    slave_clear();
    calib_done = 0; start = 1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_axi_awvalid || busy) seen++;
    end
    check("calib_held_off", seen, 0);
    calib_done = 1;
    tick();
    check("calib_aw_1cyc", m_axi_awvalid, 1'b0);
    check("calib_busy_1cyc", busy, 1'b1);
    start = 0;
    tick();
    check("calib_aw_2cyc", m_axi_awvalid, 1'b1);
    wait_done("calib");
    check("calib_pass", pass, 1'b1);

    // 6: reset in the middle of a write burst, then a clean rerun
    slave_clear();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 200; i++) begin
      if (w_total >= 2) break;
      tick();
    end
    check("midw_reached", w_total >= 2, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    check_idle("midw_rst");
    tick();
    run_test("rerun");
    check("rerun_pass", pass, 1'b1);
    check("rerun_err", err_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
